// File: rtl/voice_pkg.sv
// Shared types and constant helpers for the polyphonic voice allocator.
package voice_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } vstate_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Position of the note-on/off flag inside a UART message.
   function automatic int on_bit(input int note_w);
      return note_w;
   endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// UART key-message strobe bundle from UART_RX into the voice allocator.
interface voice_alloc_if #(
   parameter int C_UART_DATA_WIDTH = 8
);
   logic                         UART_valid;
   logic                         UART_err;
   logic [C_UART_DATA_WIDTH-1:0] UART_msg;

   modport master (output UART_valid, UART_err, UART_msg);
   modport slave  (input  UART_valid, UART_err, UART_msg);
endinterface

// File: rtl/ms_tick.sv
// 1 ms prescaler: tick_o is high for one cycle every C_CLK_FRQ/1000 cycles.
module ms_tick
   import voice_pkg::*;
#(
   parameter int C_CLK_FRQ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);
   localparam int DIV = (C_CLK_FRQ / 1000 > 1) ? C_CLK_FRQ / 1000 : 1;
   localparam int CW  = (DIV > 1) ? clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)         cnt_q <= '0;
      else if (tick_o) cnt_q <= '0;
      else             cnt_q <= cnt_q + CW'(1);
   end
endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps UART note-on/off messages onto C_NUM_VOICES
// voices with retrigger, oldest-voice stealing and per-voice auto-release.
module voice_alloc
   import voice_pkg::*;
#(
   parameter int C_CLK_FRQ         = 100_000_000,
   parameter int C_NUM_VOICES      = 4,
   parameter int C_NOTE_WIDTH      = 7,
   parameter int C_NUM_KEYS        = 13,
   parameter int C_HOLD_MS         = 500,
   parameter int C_STEAL           = 1,
   parameter int C_UART_DATA_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   voice_alloc_if.slave                         uart,
   output logic [C_NUM_VOICES-1:0]              voice_active,
   output logic [C_NUM_VOICES*C_NOTE_WIDTH-1:0] voice_note,
   output logic [C_NUM_VOICES-1:0]              voice_start,
   output logic [clog2(C_NUM_VOICES+1)-1:0]     active_cnt,
   output logic                                 evt_drop,
   output logic                                 evt_bad
);
   localparam int NV = C_NUM_VOICES;
   localparam int NW = C_NOTE_WIDTH;
   localparam int IW = (NV > 1) ? clog2(NV) : 1;
   localparam int HW = (C_HOLD_MS > 0) ? clog2(C_HOLD_MS + 1) : 1;
   localparam int CW = clog2(NV + 1);
   localparam int ON = on_bit(NW);

   if (C_UART_DATA_WIDTH < NW + 1) begin : g_err_width
      $error("voice_alloc: C_UART_DATA_WIDTH must be >= C_NOTE_WIDTH+1");
   end
   if (NV < 1 || NV > 16) begin : g_err_voices
      $error("voice_alloc: C_NUM_VOICES must be in 1..16");
   end
   if (C_UART_DATA_WIDTH > NW + 1) begin : g_sink
      logic unused_msg_hi;
      assign unused_msg_hi = ^uart.UART_msg[C_UART_DATA_WIDTH-1:NW+1];
   end

   vstate_e       st_q   [NV];
   vstate_e       st_d   [NV];
   logic [NW-1:0] note_q [NV];
   logic [NW-1:0] note_d [NV];
   logic [IW-1:0] rank_q [NV];
   logic [IW-1:0] rank_d [NV];
   logic [HW-1:0] hold_q [NV];
   logic [HW-1:0] hold_d [NV];
   logic [NV-1:0] start_q, start_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          drop_q, drop_d, bad_q, bad_d;

   logic          tick, acc, is_on, hit, free_v, tgt_v, off_v;
   logic [NW-1:0] code;
   logic [IW-1:0] hit_idx, free_idx, old_idx, tgt;
   logic [NV-1:0] act, expire, rel, surv, is_tgt;

   ms_tick #(.C_CLK_FRQ(C_CLK_FRQ)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   always_comb begin
      int r;
      code     = uart.UART_msg[NW-1:0];
      is_on    = uart.UART_msg[ON];
      acc      = uart.UART_valid && !uart.UART_err && (int'(code) < C_NUM_KEYS);
      bad_d    = uart.UART_valid && !acc;
      act      = '0;
      expire   = '0;
      hit      = 1'b0;
      hit_idx  = '0;
      free_v   = 1'b0;
      free_idx = '0;
      old_idx  = '0;
      // Descending scan so the lowest-index free voice wins.
      for (int i = NV - 1; i >= 0; i--) begin
         act[i]    = (st_q[i] == ACTIVE);
         expire[i] = (C_HOLD_MS > 0) && act[i] && tick && (int'(hold_q[i]) == C_HOLD_MS - 1);
         if (act[i] && note_q[i] == code) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!act[i] || expire[i]) begin
            free_v   = 1'b1;
            free_idx = IW'(i);
         end
         if (act[i] && int'(rank_q[i]) == NV - 1) old_idx = IW'(i);
      end

      tgt_v  = 1'b0;
      tgt    = hit_idx;
      drop_d = 1'b0;
      if (acc && is_on) begin
         if (hit) begin
            tgt_v = 1'b1;
         end else if (free_v) begin
            tgt_v = 1'b1;
            tgt   = free_idx;
         end else if (C_STEAL != 0) begin
            tgt_v = 1'b1;
            tgt   = old_idx;
         end else begin
            drop_d = 1'b1;
         end
      end
      off_v = acc && !is_on && hit;

      is_tgt = '0;
      rel    = '0;
      surv   = '0;
      for (int i = 0; i < NV; i++) begin
         is_tgt[i] = tgt_v && (tgt == IW'(i));
         rel[i]    = expire[i] || (off_v && hit_idx == IW'(i));
         surv[i]   = act[i] && !rel[i] && !is_tgt[i];
      end

      // New age order: the target first, then survivors in their old order.
      cnt_d = '0;
      for (int i = 0; i < NV; i++) begin
         r = tgt_v ? 1 : 0;
         for (int k = 0; k < NV; k++) begin
            if (surv[k] && rank_q[k] < rank_q[i]) r++;
         end
         st_d[i]   = IDLE;
         note_d[i] = '0;
         rank_d[i] = '0;
         hold_d[i] = '0;
         if (is_tgt[i]) begin
            st_d[i]   = ACTIVE;
            note_d[i] = code;
         end else if (surv[i]) begin
            st_d[i]   = ACTIVE;
            note_d[i] = note_q[i];
            rank_d[i] = IW'(r);
            hold_d[i] = (tick && hold_q[i] != HW'(C_HOLD_MS)) ? hold_q[i] + HW'(1) : hold_q[i];
         end
         if (st_d[i] == ACTIVE) cnt_d = cnt_d + CW'(1);
      end
      start_d = is_tgt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NV; i++) begin
            st_q[i]   <= IDLE;
            note_q[i] <= '0;
            rank_q[i] <= '0;
            hold_q[i] <= '0;
         end
         start_q <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NV; i++) begin
            st_q[i]   <= st_d[i];
            note_q[i] <= note_d[i];
            rank_q[i] <= rank_d[i];
            hold_q[i] <= hold_d[i];
         end
         start_q <= start_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         bad_q   <= bad_d;
      end
   end

   for (genvar g = 0; g < NV; g++) begin : g_out
      assign voice_active[g]        = (st_q[g] == ACTIVE);
      assign voice_note[g*NW +: NW] = note_q[g];
   end
   assign voice_start = start_q;
   assign active_cnt  = cnt_q;
   assign evt_drop    = drop_q;
   assign evt_bad     = bad_q;
endmodule
